// File: rtl/huff_pkg.sv
// Shared constants and state encoding for the canonical-Huffman code scheduler.
//   MAX_LEN : longest code length handled (lengths 1..15, 0 = unused symbol)
//   LEN_BIT : width of a code length
//   state_t : scheduler phases
package huff_pkg;

   localparam int unsigned MAX_LEN = 15;
   localparam int unsigned LEN_BIT = 4;

   typedef enum logic [2:0] {IDLE, COUNT, CALC, ASSIGN, DONE} state_t;

endpackage

// File: rtl/huff_len_mem.sv
// Code-length storage: 2^SYM_BIT entries of LEN_BIT bits.
//   clock   : rising-edge clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : length to store
//   rd_addr : read address, sampled on the clock edge
//   rd_data : registered read data (one-cycle latency)
// Contents are not reset; every table overwrites the entries it uses.
module huff_len_mem
   import huff_pkg::*;
#(
   parameter int unsigned SYM_BIT = 5
) (
   input  logic               clock,
   input  logic               wr_en,
   input  logic [SYM_BIT-1:0] wr_addr,
   input  logic [LEN_BIT-1:0] wr_data,
   input  logic [SYM_BIT-1:0] rd_addr,
   output logic [LEN_BIT-1:0] rd_data
);

   logic [LEN_BIT-1:0] mem [2**SYM_BIT];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/huff_code_sched.sv
// Canonical-Huffman table-build sequencer: collects one code-length stream,
// builds the length histogram and next-code array, then emits one canonical
// code per used symbol in symbol order.
//   clock, reset          : rising-edge clock, async active-low reset
//   start                 : begin a new table (honoured in IDLE/DONE only)
//   len_valid/ready/in/last : code-length input stream
//   code_valid/ready      : assigned-code output handshake
//   code_out/len/sym      : canonical code, its length and symbol index
//   busy                  : high in COUNT, CALC and ASSIGN
//   sig_end               : table complete, held until next start
//   err                   : oversubscribed length set, held until next start
module huff_code_sched
   import huff_pkg::*;
#(
   parameter int unsigned COUNT_BIT = 6,
   parameter int unsigned SYM_BIT   = 5,
   parameter int unsigned CODE_BIT  = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic                len_valid,
   output logic                len_ready,
   input  logic [LEN_BIT-1:0]  len_in,
   input  logic                len_last,
   output logic                code_valid,
   input  logic                code_ready,
   output logic [CODE_BIT-1:0] code_out,
   output logic [LEN_BIT-1:0]  code_len,
   output logic [SYM_BIT-1:0]  code_sym,
   output logic                busy,
   output logic                sig_end,
   output logic                err
);

   localparam int unsigned NSYM = 2**SYM_BIT;

   state_t               state;
   logic [SYM_BIT:0]     sym_cnt;     // symbols accepted in COUNT
   logic [SYM_BIT-1:0]   ptr;         // symbol whose length sits on mem_rdata
   logic                 fetch_done;  // last symbol already moved to the output
   logic [LEN_BIT-1:0]   calc_k;
   logic [COUNT_BIT-1:0] bl_count  [MAX_LEN+1];
   logic [CODE_BIT-1:0]  next_code [MAX_LEN+1];

   logic                 beat, last_beat, advance, last_ptr;
   logic                 mem_we;
   logic [SYM_BIT-1:0]   mem_raddr;
   logic [LEN_BIT-1:0]   mem_rdata;
   logic [CODE_BIT-1:0]  calc_next;
   logic [CODE_BIT:0]    calc_sum, calc_lim;
   logic                 calc_over;

   assign beat      = (state == COUNT) && len_valid && len_ready;
   assign last_beat = len_last || (sym_cnt == (SYM_BIT+1)'(NSYM - 1));
   assign mem_we    = beat;
   assign advance   = !code_valid || code_ready;
   assign last_ptr  = ({1'b0, ptr} == sym_cnt - (SYM_BIT+1)'(1));

   // Fetch one symbol ahead whenever the output stage frees up, so a new
   // length is on mem_rdata every cycle; otherwise re-read the same entry.
   assign mem_raddr = (state == ASSIGN && advance && !fetch_done) ? ptr + SYM_BIT'(1) : ptr;

   // One CALC step: next[k] from next[k-1], plus the Kraft-style overflow check.
   always_comb begin
      calc_next = '0;
      if (calc_k != LEN_BIT'(1)) begin
         calc_next = (next_code[calc_k - LEN_BIT'(1)]
                      + CODE_BIT'(bl_count[calc_k - LEN_BIT'(1)])) << 1;
      end
      calc_sum  = {1'b0, calc_next} + (CODE_BIT+1)'(bl_count[calc_k]);
      calc_lim  = (CODE_BIT+1)'(1) << calc_k;
      calc_over = calc_sum > calc_lim;
   end

   huff_len_mem #(
      .SYM_BIT (SYM_BIT)
   ) u_len_mem (
      .clock   (clock),
      .wr_en   (mem_we),
      .wr_addr (sym_cnt[SYM_BIT-1:0]),
      .wr_data (len_in),
      .rd_addr (mem_raddr),
      .rd_data (mem_rdata)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         sym_cnt    <= '0;
         ptr        <= '0;
         fetch_done <= 1'b0;
         calc_k     <= '0;
         len_ready  <= 1'b0;
         code_valid <= 1'b0;
         code_out   <= '0;
         code_len   <= '0;
         code_sym   <= '0;
         busy       <= 1'b0;
         sig_end    <= 1'b0;
         err        <= 1'b0;
         for (int i = 0; i <= MAX_LEN; i++) begin
            bl_count[i]  <= '0;
            next_code[i] <= '0;
         end
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  for (int i = 0; i <= MAX_LEN; i++) begin
                     bl_count[i] <= '0;
                  end
                  sym_cnt    <= '0;
                  ptr        <= '0;
                  fetch_done <= 1'b0;
                  sig_end    <= 1'b0;
                  err        <= 1'b0;
                  busy       <= 1'b1;
                  len_ready  <= 1'b1;
                  state      <= COUNT;
               end
            end
            COUNT: begin
               if (beat) begin
                  if (len_in != '0) begin
                     bl_count[len_in] <= bl_count[len_in] + COUNT_BIT'(1);
                  end
                  sym_cnt <= sym_cnt + (SYM_BIT+1)'(1);
                  if (last_beat) begin
                     len_ready <= 1'b0;
                     calc_k    <= LEN_BIT'(1);
                     state     <= CALC;
                  end
               end
            end
            CALC: begin
               next_code[calc_k] <= calc_next;
               if (calc_over) begin
                  err <= 1'b1;
               end
               if (calc_k == LEN_BIT'(MAX_LEN)) begin
                  if (err || calc_over) begin
                     busy    <= 1'b0;
                     sig_end <= 1'b1;
                     state   <= DONE;
                  end else begin
                     state <= ASSIGN;
                  end
               end else begin
                  calc_k <= calc_k + LEN_BIT'(1);
               end
            end
            ASSIGN: begin
               if (advance) begin
                  if (fetch_done) begin
                     code_valid <= 1'b0;
                     busy       <= 1'b0;
                     sig_end    <= 1'b1;
                     state      <= DONE;
                  end else begin
                     // Codes are claimed when loaded into the output stage; the
                     // output order is identical to claiming on handshake.
                     code_valid <= (mem_rdata != '0);
                     if (mem_rdata != '0) begin
                        code_out             <= next_code[mem_rdata];
                        code_len             <= mem_rdata;
                        code_sym             <= ptr;
                        next_code[mem_rdata] <= next_code[mem_rdata] + CODE_BIT'(1);
                     end
                     if (last_ptr) begin
                        if (mem_rdata == '0) begin
                           busy    <= 1'b0;
                           sig_end <= 1'b1;
                           state   <= DONE;
                        end else begin
                           fetch_done <= 1'b1;
                        end
                     end else begin
                        ptr <= ptr + SYM_BIT'(1);
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_huff_code_sched.sv
// Directed self-checking bench for huff_code_sched.
module tb_huff_code_sched;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        len_valid;
   logic        len_ready;
   logic [3:0]  len_in;
   logic        len_last;
   logic        code_valid;
   logic        code_ready;
   logic [15:0] code_out;
   logic [3:0]  code_len;
   logic [4:0]  code_sym;
   logic        busy;
   logic        sig_end;
   logic        err;

   int vectors = 0;
   int miscompares = 0;

   logic [3:0]  feed_len [32];
   logic [15:0] exp_code [32];
   logic [3:0]  exp_len  [32];
   logic [4:0]  exp_sym  [32];

   huff_code_sched dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .len_valid  (len_valid),
      .len_ready  (len_ready),
      .len_in     (len_in),
      .len_last   (len_last),
      .code_valid (code_valid),
      .code_ready (code_ready),
      .code_out   (code_out),
      .code_len   (code_len),
      .code_sym   (code_sym),
      .busy       (busy),
      .sig_end    (sig_end),
      .err        (err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_len_ready"}, len_ready, 0);
      chk({tag, "_code_valid"}, code_valid, 0);
      chk({tag, "_code_out"}, code_out, 0);
      chk({tag, "_code_len"}, code_len, 0);
      chk({tag, "_code_sym"}, code_sym, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_sig_end"}, sig_end, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   task automatic begin_table();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      chk("start_busy", busy, 1);
      chk("start_err_clr", err, 0);
      chk("start_end_clr", sig_end, 0);
   endtask

   // Returns at the negedge following the clock edge that took the final beat.
   task automatic feed(input int n, input bit use_last);
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         chk("len_ready_count", len_ready, 1);
         len_valid = 1'b1;
         len_in    = feed_len[i];
         len_last  = use_last && (i == n - 1);
      end
      @(negedge clock);
      len_valid = 1'b0;
      len_last  = 1'b0;
      len_in    = '0;
      chk("len_ready_drop", len_ready, 0);
   endtask

   task automatic load_first_test();
      logic [3:0]  l [8] = '{4'd3, 4'd3, 4'd3, 4'd3, 4'd3, 4'd2, 4'd4, 4'd4};
      logic [15:0] c [8] = '{16'h2, 16'h3, 16'h4, 16'h5, 16'h6, 16'h0, 16'hE, 16'hF};
      for (int i = 0; i < 8; i++) begin
         feed_len[i] = l[i];
         exp_code[i] = c[i];
         exp_len[i]  = l[i];
         exp_sym[i]  = 5'(i);
      end
   endtask

   // Consumes codes, checking each handshake against the expected table and
   // holding-stability while stalled. stop_after=0 runs until sig_end.
   task automatic run_codes(input int n_exp, input bit toggle, input int stop_after,
                            output int got);
      logic [15:0] h_code = '0;
      logic [3:0]  h_len  = '0;
      logic [4:0]  h_sym  = '0;
      bit          stalled = 0;
      bit          done = 0;
      got = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clock);
         if (stalled) begin
            chk("stall_valid", code_valid, 1);
            chk("stall_code", code_out, h_code);
            chk("stall_len", code_len, h_len);
            chk("stall_sym", code_sym, h_sym);
         end
         if (sig_end || (stop_after != 0 && got == stop_after)) begin
            done = 1;
            break;
         end
         code_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
         stalled = 0;
         if (code_valid) begin
            if (code_ready) begin
               if (got < n_exp) begin
                  chk("code_out", code_out, exp_code[got]);
                  chk("code_len", code_len, exp_len[got]);
                  chk("code_sym", code_sym, exp_sym[got]);
               end
               got++;
            end else begin
               stalled = 1;
               h_code  = code_out;
               h_len   = code_len;
               h_sym   = code_sym;
            end
         end
      end
      chk("codes_done_in_budget", done, 1);
   endtask

   task automatic check_done_ok(input string tag);
      chk({tag, "_sig_end"}, sig_end, 1);
      chk({tag, "_err"}, err, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_code_valid"}, code_valid, 0);
   endtask

   initial begin
      int  got;
      bit  saw_valid;

      reset = 1'b0;
      start = 1'b0;
      len_valid = 1'b0;
      len_in = '0;
      len_last = 1'b0;
      code_ready = 1'b0;

      // Reset state.
      #3;
      chk_idle_outputs("reset");
      @(negedge clock);
      reset = 1'b1;

      // Mixed lengths, no backpressure.
      load_first_test();
      begin_table();
      feed(8, 1);
      run_codes(8, 0, 0, got);
      chk("t1_count", got, 8);
      check_done_ok("t1");

      // All-zero lengths: 15 CALC cycles + 5 skip cycles, no output.
      for (int i = 0; i < 5; i++) feed_len[i] = 4'd0;
      begin_table();
      feed(5, 1);
      saw_valid = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock);
         if (code_valid) saw_valid = 1;
         if (i == 19) chk("t2_end_early", sig_end, 0);
         if (i == 20) chk("t2_end_on_time", sig_end, 1);
      end
      chk("t2_no_code", saw_valid, 0);
      chk("t2_err", err, 0);
      chk("t2_busy", busy, 0);

      // Oversubscribed: three length-1 codes.
      for (int i = 0; i < 3; i++) feed_len[i] = 4'd1;
      begin_table();
      feed(3, 1);
      saw_valid = 0;
      for (int i = 1; i <= 15; i++) begin
         @(negedge clock);
         if (code_valid) saw_valid = 1;
         if (i == 1) chk("t3_err_step1", err, 1);
         if (i == 1) chk("t3_busy_calc", busy, 1);
         if (i == 14) chk("t3_end_early", sig_end, 0);
         if (i == 15) chk("t3_end", sig_end, 1);
      end
      chk("t3_no_code", saw_valid, 0);
      chk("t3_err_held", err, 1);

      // Backpressure on the first table.
      load_first_test();
      begin_table();
      feed(8, 1);
      run_codes(8, 1, 0, got);
      chk("t4_count", got, 8);
      check_done_ok("t4");

      // Reset in ASSIGN after three codes, then a clean rerun.
      begin_table();
      feed(8, 1);
      run_codes(8, 0, 3, got);
      chk("t5_partial", got, 3);
      reset = 1'b0;
      code_ready = 1'b0;
      #1;
      chk_idle_outputs("t5_reset");
      @(negedge clock);
      reset = 1'b1;
      begin_table();
      feed(8, 1);
      run_codes(8, 0, 0, got);
      chk("t5_count", got, 8);
      check_done_ok("t5");

      // 32 length-5 symbols with no len_last; stray beats during CALC ignored.
      for (int i = 0; i < 32; i++) begin
         feed_len[i] = 4'd5;
         exp_code[i] = 16'(i);
         exp_len[i]  = 4'd5;
         exp_sym[i]  = 5'(i);
      end
      begin_table();
      feed(32, 0);
      len_valid = 1'b1;
      len_in    = 4'd1;
      len_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         chk("t6_ready_low", len_ready, 0);
      end
      len_valid = 1'b0;
      len_in    = '0;
      len_last  = 1'b0;
      run_codes(32, 0, 0, got);
      chk("t6_count", got, 32);
      check_done_ok("t6");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/huff_code_sched.md
Name: huff_code_sched

Overview:
- Sequencer for the canonical-Huffman next-code datapath in the decompressor's table-build stage.
- Accepts one code-length stream per table, builds the per-length histogram and the next-code array, then assigns one canonical code per symbol in symbol order.
- Output feeds the decode-table writer.
- Drives the count, calc, assign and done phases of the table build and owns the histogram and next-code storage.

Parameters:
- COUNT_BIT, 6, histogram counter width; must be at least SYM_BIT+1.
- SYM_BIT, 5, symbol index width; maximum table size is 2^SYM_BIT symbols.
- CODE_BIT, 16, next-code and code width; must be at least MAX_LEN+1.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a new table when in IDLE or DONE
- len_valid  in  1  code-length input valid
- len_ready  out  1  scheduler accepts a code length
- len_in  in  4  code length, 0..15; 0 means the symbol is unused
- len_last  in  1  marks the final symbol of the table
- code_valid  out  1  assigned code valid
- code_ready  in  1  downstream accepts the code
- code_out  out  CODE_BIT  canonical code, right-aligned
- code_len  out  4  length of code_out
- code_sym  out  SYM_BIT  symbol index of code_out
- busy  out  1  high in COUNT, CALC and ASSIGN
- sig_end  out  1  table complete; held high until the next start
- err  out  1  oversubscribed length set; held high until the next start

Behaviour:
- Reset (async, reset=0): state=IDLE; all outputs 0; histogram, next-code array and symbol counter cleared. A reset mid-operation aborts immediately. Length-memory contents are don't-care.
- States: IDLE, COUNT, CALC, ASSIGN, DONE.
- IDLE/DONE:
  - start=1 clears the histogram, symbol counter, sig_end and err, then moves to COUNT.
  - start in any other state is ignored.
- COUNT:
  - len_ready=1.
  - On each len_valid&len_ready: write len_in to the length memory at the symbol counter; if len_in!=0, increment bl_count[len_in]; increment the symbol counter.
  - Transition to CALC after accepting the beat with len_last=1, or the beat at index 2^SYM_BIT-1, whichever comes first. len_ready drops the following cycle.
- CALC: exactly 15 cycles, one per step k=1..15.
  - next[0]=next[1]=0.
  - For k>=2: next[k]=(next[k-1]+bl_count[k-1])<<1, computed at width CODE_BIT.
  - Oversubscription check at each step k: next[k]+bl_count[k] > 2^k sets err.
  - After step 15: go to DONE if err=1, otherwise to ASSIGN with the symbol pointer at 0.
- ASSIGN:
  - Visit symbols 0..N-1 in order, where N is the number of symbols accepted.
  - len=0: skip the symbol in one cycle, no output.
  - len!=0: present code_out=next[len], code_len=len, code_sym=index with code_valid=1.
    - code_out, code_len and code_sym hold stable until code_ready=1.
    - On handshake, next[len] increments and the pointer advances.
  - Throughput: one code per cycle while code_ready=1.
  - After the last symbol: go to DONE; code_valid returns to 0.
- DONE: sig_end=1, busy=0.
- Corner cases:
  - All-zero lengths: ASSIGN emits nothing; err=0; the table ends in DONE.
  - len_valid outside COUNT is ignored.

Decomposition:
- Package huff_pkg: MAX_LEN=15, LEN_BIT=4, state enum {IDLE, COUNT, CALC, ASSIGN, DONE}.
- Sub-module huff_len_mem: 2^SYM_BIT x 4 storage with one synchronous write port and one synchronous read port.
  - The ASSIGN read is pipelined one cycle ahead so the 1-code-per-cycle throughput holds.
- Histogram, next-code array and FSM stay in the top module.

Test Plan:
- Lengths A-H = 3,3,3,3,3,2,4,4 with last on H -> codes in symbol order:
  - A 010/3, B 011/3, C 100/3, D 101/3, E 110/3, F 00/2, G 1110/4, H 1111/4.
  - Afterwards sig_end=1, err=0.
- Five symbols, all length 0 -> no code_valid; sig_end after 15 CALC cycles plus 5 skip cycles; err=0.
- Three symbols of length 1 -> err=1 at CALC; no codes emitted; DONE reached with sig_end=1.
- Backpressure: the first test with code_ready toggling randomly -> code_out, code_len and code_sym stable while stalled; exact same 8-code sequence, no drops or duplicates.
- Reset pulled low during ASSIGN after 3 codes -> all outputs 0 immediately and state IDLE; rerunning the first test produces the full correct sequence.
- 32 symbols of length 5 with no len_last -> the 32nd beat is treated as last and len_ready=0 afterwards; codes 0..31 are emitted at length 5; err=0.
